// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row, debounces the first low column
// it finds, and emits one key_valid pulse per accepted press while shifting the s1/s2 history.
module keypad_scanner #(
    parameter int SCAN_DIV       = 24000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] s1,
    output logic [3:0] s2
);
    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   tick_cnt_reg;
    logic            tick;
    logic [1:0]      row_idx_reg, row_idx_next;
    logic [1:0]      col_idx_reg, col_idx_next;
    logic [DW-1:0]   db_cnt_reg, db_cnt_next;
    logic [3:0]      key_code_reg, key_code_next;
    logic            key_valid_reg, key_valid_next;
    logic [3:0]      s1_reg, s1_next;
    logic [3:0]      s2_reg, s2_next;
    logic [1:0]      low_col;
    logic [3:0]      code;

    assign tick = (tick_cnt_reg == TW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset || tick) tick_cnt_reg <= '0;
        else                tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end

    // One-cold row drive decoded straight from the row index
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rows
            assign rows[gi] = (row_idx_reg != 2'(gi));
        end
    endgenerate

    always_comb begin
        casez (cols)
            4'b???0: low_col = 2'd0;
            4'b??01: low_col = 2'd1;
            4'b?011: low_col = 2'd2;
            default: low_col = 2'd3;
        endcase
    end

    always_comb begin
        case ({row_idx_reg, col_idx_reg})
            4'd0:  code = 4'h1;  4'd1:  code = 4'h2;  4'd2:  code = 4'h3;  4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;  4'd5:  code = 4'h5;  4'd6:  code = 4'h6;  4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;  4'd9:  code = 4'h8;  4'd10: code = 4'h9;  4'd11: code = 4'hC;
            4'd12: code = 4'hE;  4'd13: code = 4'h0;  4'd14: code = 4'hF;  default: code = 4'hD;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        row_idx_next   = row_idx_reg;
        col_idx_next   = col_idx_reg;
        db_cnt_next    = db_cnt_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        s1_next        = s1_reg;
        s2_next        = s2_reg;
        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (cols == 4'hF) begin
                        row_idx_next = row_idx_reg + 2'd1;
                    end else begin
                        col_idx_next = low_col;
                        db_cnt_next  = '0;
                        state_next   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!cols[col_idx_reg]) begin
                        if (db_cnt_reg == DW'(DEBOUNCE_TICKS - 1)) begin
                            state_next     = HELD;
                            db_cnt_next    = '0;
                            key_code_next  = code;
                            s2_next        = s1_reg;
                            s1_next        = code;
                            key_valid_next = 1'b1;
                        end else begin
                            db_cnt_next = db_cnt_reg + DW'(1);
                        end
                    end else begin
                        state_next   = SCAN;
                        row_idx_next = row_idx_reg + 2'd1;
                    end
                end
                HELD: begin
                    // Only the latched column matters here; other keys are invisible until release
                    if (cols[col_idx_reg]) begin
                        if (db_cnt_reg == DW'(DEBOUNCE_TICKS - 1)) begin
                            state_next   = SCAN;
                            db_cnt_next  = '0;
                            row_idx_next = row_idx_reg + 2'd1;
                        end else begin
                            db_cnt_next = db_cnt_reg + DW'(1);
                        end
                    end else begin
                        db_cnt_next = '0;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= SCAN;
            row_idx_reg   <= '0;
            col_idx_reg   <= '0;
            db_cnt_reg    <= '0;
            key_code_reg  <= '0;
            key_valid_reg <= 1'b0;
            s1_reg        <= '0;
            s2_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            row_idx_reg   <= row_idx_next;
            col_idx_reg   <= col_idx_next;
            db_cnt_reg    <= db_cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            s1_reg        <= s1_next;
            s2_reg        <= s2_next;
        end
    end

    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign s1        = s1_reg;
    assign s2        = s2_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix drives cols from rows; each physical
// press queues its expected event and a monitor checks every key_valid pulse against it.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cols, rows, key_code, s1, s2;
    logic       key_valid;

    logic [3:0] keys [4];
    logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    typedef struct {
        logic [3:0] code;
        logic [3:0] s1;
        logic [3:0] s2;
    } exp_t;
    exp_t exp_q[$];
    logic [3:0] m_s1 = 4'h0, m_s2 = 4'h0;

    int checks = 0, passed = 0, events = 0;
    logic prev_kv = 1'b0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEB)) dut (
        .clk(clk), .reset(reset), .cols(cols), .rows(rows),
        .key_code(key_code), .key_valid(key_valid), .s1(s1), .s2(s2)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its column low whenever its row is driven low
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && keys[r][c]) cols[c] = 1'b0;
    end

    task automatic check(string name, int act, int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_key(int r, int c);
        exp_t e;
        m_s2 = m_s1;
        m_s1 = key_tab[r*4 + c];
        e.code = m_s1; e.s1 = m_s1; e.s2 = m_s2;
        exp_q.push_back(e);
    endtask

    task automatic press_cycle(int r, int c, bit start_bounce, int nglitch, int hold);
        expect_key(r, c);
        if (start_bounce) begin
            keys[r][c] = 1'b1; wait_clk(SCAN_DIV);
            keys[r][c] = 1'b0; wait_clk(SCAN_DIV);
        end
        keys[r][c] = 1'b1;
        wait_clk(hold);
        // Release bounces: low stretches too short to reach the release threshold
        repeat (nglitch) begin
            keys[r][c] = 1'b0; wait_clk(2*SCAN_DIV);
            keys[r][c] = 1'b1; wait_clk(SCAN_DIV);
        end
        keys[r][c] = 1'b0;
        wait_clk(30);
    endtask

    task automatic held_other(int ra, int ca, int rb, int cb, int nglitch);
        expect_key(ra, ca);
        keys[ra][ca] = 1'b1;
        wait_clk(60);
        expect_key(rb, cb);
        keys[rb][cb] = 1'b1;
        wait_clk(20);
        repeat (nglitch) begin
            keys[ra][ca] = 1'b0; wait_clk(2*SCAN_DIV);
            keys[ra][ca] = 1'b1; wait_clk(SCAN_DIV);
        end
        keys[ra][ca] = 1'b0;
        wait_clk(80);
        keys[rb][cb] = 1'b0;
        wait_clk(30);
    endtask

    // Monitor: every key_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        check("rows_one_cold", $countones(~rows), 1);
        if (key_valid) begin
            events++;
            check("kv_not_consecutive", int'(prev_kv), 0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event key_code=%h required=no_event at %0t", key_code, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("event %0d: key_code=%h s1=%h s2=%h (expected %h/%h/%h)",
                         events, key_code, s1, s2, e.code, e.s1, e.s2);
                check("key_code", key_code, e.code);
                check("s1", s1, e.s1);
                check("s2", s2, e.s2);
            end
        end
        prev_kv <= key_valid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 4; r++) keys[r] = 4'h0;
        reset = 1'b0;
        wait_clk(3);
        check("reset_rows", rows, 4'b1110);
        check("reset_key_code", key_code, 0);
        check("reset_key_valid", key_valid, 0);
        check("reset_s1", s1, 0);
        check("reset_s2", s2, 0);
        reset = 1'b1;

        // Idle scan: one row step per SCAN_DIV clocks
        for (int k = 1; k <= 20; k++) begin
            wait_clk(1);
            check("idle_rows", rows, int'(~(4'b0001 << ((k / SCAN_DIV) % 4)) & 4'hF));
        end

        press_cycle(1, 2, 1'b0, 0, 80);

        expect_key(3, 1);
        keys[3][1] = 1'b1;
        wait_clk(50);
        repeat (3) begin
            check("held_rows_frozen", rows, 4'b0111);
            wait_clk(SCAN_DIV);
        end
        wait_clk(20);
        keys[3][1] = 1'b0;
        wait_clk(30);

        press_cycle(0, 0, 1'b1, 0, 80);
        held_other(2, 3, 0, 1, 2);

        // Same-row multi-key: lowest column wins
        for (int i = 0; i < 3; i++) begin
            int r, ca, cb;
            r = $urandom_range(0, 3);
            ca = $urandom_range(0, 2);
            cb = $urandom_range(ca + 1, 3);
            expect_key(r, ca);
            keys[r][ca] = 1'b1; keys[r][cb] = 1'b1;
            wait_clk(70);
            keys[r][ca] = 1'b0; keys[r][cb] = 1'b0;
            wait_clk(30);
        end

        for (int i = 0; i < 12; i++)
            press_cycle($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 2), $urandom_range(60, 100));

        for (int i = 0; i < 3; i++) begin
            int ka, kb;
            ka = $urandom_range(0, 15);
            kb = (ka + $urandom_range(1, 15)) % 16;
            held_other(ka / 4, ka % 4, kb / 4, kb % 4, $urandom_range(0, 2));
        end

        // Reset asserted while r1c0 is being debounced
        reset = 1'b0; wait_clk(2); reset = 1'b1;
        keys[1][0] = 1'b1;
        wait_clk(14);
        reset = 1'b0;
        keys[1][0] = 1'b0;
        wait_clk(2);
        check("midreset_rows", rows, 4'b1110);
        check("midreset_key_code", key_code, 0);
        check("midreset_key_valid", key_valid, 0);
        check("midreset_s1", s1, 0);
        check("midreset_s2", s2, 0);
        m_s1 = 4'h0; m_s2 = 4'h0;
        reset = 1'b1;
        wait_clk(1);
        check("restart_rows", rows, 4'b1110);
        press_cycle(2, 1, 1'b0, 1, 80);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_clk(1);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
